ide_pio: RTL and testbench

Parametrised ATA PIO cycle engine between the disk controller state machine and the IDE connector. It turns a single read or write request into a fully timed ATA register/data cycle: address setup, DIOR-/DIOW- strobe, hold and recovery. Setup, strobe and recovery lengths are set in clock cycles, and the strobe can optionally be stretched by the drive's IORDY line. It keeps the existing `ata_*`/`ide_*` port naming so the controller can swap it in with few changes.

---
 rtl/ide_pkg.sv | 39 +++
 rtl/ide_sync2.sv | 27 ++
 rtl/ide_pio.sv | 203 ++++++++++++++++++++
 tb/tb_ide_pio.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ide_pkg.sv
// ide_pkg: shared definitions for the ATA PIO cycle engine.
//   - ide_state_e   : cycle engine states (3-bit encoding, also exported on dbg_state)
//   - ATA_REG_*     : {cs[1:0], da[2:0]} addresses of the ATA task-file registers
//   - clog2()       : ceil(log2(v)), used to size the shared down-counter
// Optional feature macro used by the engine: IDE_IORDY_EN (IORDY strobe stretching).
package ide_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } ide_state_e;

  // Command block registers live at cs = 2'b10, control block at cs = 2'b01.
  localparam logic [4:0] ATA_REG_DATA       = 5'b10000;
  localparam logic [4:0] ATA_REG_ERR_FEAT   = 5'b10001;
  localparam logic [4:0] ATA_REG_SECCNT     = 5'b10010;
  localparam logic [4:0] ATA_REG_LBA_LO     = 5'b10011;
  localparam logic [4:0] ATA_REG_LBA_MID    = 5'b10100;
  localparam logic [4:0] ATA_REG_LBA_HI     = 5'b10101;
  localparam logic [4:0] ATA_REG_DEVICE     = 5'b10110;
  localparam logic [4:0] ATA_REG_STATUS_CMD = 5'b10111;
  localparam logic [4:0] ATA_REG_ALTSTATUS  = 5'b01110;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ide_sync2.sv
// ide_sync2: generic two-flop synchroniser for a single asynchronous input.
//   clk   in  : destination clock
//   reset in  : synchronous active-high reset, both flops load RESET_VAL
//   d     in  : asynchronous input
//   q     out : synchronised output, two clk cycles of latency
module ide_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ide_pio.sv
// ide_pio: ATA PIO cycle engine. Turns one read/write request into a timed
// IDE register/data cycle: address setup, DIOR-/DIOW- strobe, hold, recovery.
//
// Optional feature: define IDE_IORDY_EN to let the drive stretch the strobe
// through IORDY (bounded by IORDY_TIMEOUT extra cycles, flagged on ata_err).
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   ata_rd / ata_wr      : request, sampled only in IDLE (exactly one high)
//   ata_addr, ata_in     : {cs,da} and write data, latched on accept
//   ata_out              : last read data (valid from HOLD, held until next read)
//   ata_done             : one-cycle completion pulse (first RECOVER cycle)
//   ata_busy             : high from accept until return to IDLE
//   ata_err              : IORDY timeout flag, valid with ata_done
//   ide_data_bus         : IDE data bus (driven only for writes)
//   ide_dior / ide_diow  : active-low strobes
//   ide_cs / ide_da      : chip selects (active low) and device address
//   ide_iordy            : drive IORDY, asynchronous
//   dbg_state            : current engine state (ide_state_e encoding)
//
// Handshake: the controller raises ata_rd or ata_wr while ata_busy is low;
// a request is taken on that clock edge (a one-cycle pulse is enough) and
// ata_busy rises. Requests seen while busy are dropped, not queued. The
// cycle completes with a single-cycle ata_done; a new request is accepted
// once ata_busy is low again.
module ide_pio
  import ide_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int T_SETUP       = 1,
  parameter int T_ACTIVE      = 3,
  parameter int T_RECOVER     = 2,
  parameter int IORDY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ata_rd,
  input  logic              ata_wr,
  input  logic [4:0]        ata_addr,
  input  logic [DATA_W-1:0] ata_in,
  output logic [DATA_W-1:0] ata_out,
  output logic              ata_done,
  output logic              ata_busy,
  output logic              ata_err,
  inout  wire  [DATA_W-1:0] ide_data_bus,
  output logic              ide_dior,
  output logic              ide_diow,
  output logic [1:0]        ide_cs,
  output logic [2:0]        ide_da,
  input  logic              ide_iordy,
  output logic [2:0]        dbg_state
);

  localparam int MAX_SA  = (T_SETUP > T_ACTIVE) ? T_SETUP : T_ACTIVE;
  localparam int MAX_SAR = (MAX_SA > T_RECOVER) ? MAX_SA : T_RECOVER;
  localparam int CNT_MAX = (MAX_SAR > IORDY_TIMEOUT) ? MAX_SAR : IORDY_TIMEOUT;
  localparam int CW      = clog2(CNT_MAX + 1);

  ide_state_e        state;
  logic [CW-1:0]     cnt;
  logic              is_rd;
  logic [4:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic accept;
  logic cnt_zero;
  logic addr_phase;
  logic strobe_exit;       // last STROBE cycle
  logic strobe_ext_start;  // T_ACTIVE done but IORDY still low
  logic strobe_timeout;    // leaving STROBE because the IORDY budget ran out

  assign accept   = (state == S_IDLE) && (ata_rd ^ ata_wr);
  assign cnt_zero = (cnt == '0);

`ifdef IDE_IORDY_EN
  logic iordy_s;
  logic ext_q;   // strobe is in the IORDY-stretch phase
  logic err_q;

  ide_sync2 #(.RESET_VAL(1'b0)) u_iordy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ide_iordy),
    .q     (iordy_s)
  );

  // The same counter first times T_ACTIVE, then is reloaded with the
  // timeout budget if the drive is still holding IORDY low.
  always_comb begin
    strobe_exit      = ext_q ? (iordy_s | cnt_zero) : (cnt_zero & iordy_s);
    strobe_ext_start = ~ext_q & cnt_zero & ~iordy_s;
    strobe_timeout   = ext_q & cnt_zero & ~iordy_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end
      if (state == S_STROBE) begin
        if (strobe_exit) begin
          ext_q <= 1'b0;
          if (strobe_timeout) begin
            err_q <= 1'b1;
          end
        end else if (strobe_ext_start) begin
          ext_q <= 1'b1;
        end
      end
    end
  end

  assign ata_err = err_q;
`else
  logic unused_iordy;
  assign unused_iordy = ide_iordy;

  always_comb begin
    strobe_exit      = cnt_zero;
    strobe_ext_start = 1'b0;
    strobe_timeout   = 1'b0;
  end

  assign ata_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      addr_q   <= 5'b11111;
      wdata_q  <= '0;
      ata_out  <= '0;
      ata_done <= 1'b0;
    end else begin
      ata_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_SETUP;
            cnt     <= CW'(T_SETUP - 1);
            is_rd   <= ata_rd;
            addr_q  <= ata_addr;
            wdata_q <= ata_in;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state <= S_STROBE;
            cnt   <= CW'(T_ACTIVE - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STROBE: begin
          if (strobe_exit) begin
            state <= S_HOLD;
            cnt   <= '0;
            if (is_rd) begin
              ata_out <= ide_data_bus;
            end
          end else if (strobe_ext_start) begin
            cnt <= CW'(IORDY_TIMEOUT - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          state    <= S_RECOVER;
          cnt      <= CW'(T_RECOVER - 1);
          ata_done <= 1'b1;
        end
        S_RECOVER: begin
          if (cnt_zero) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Address and write data stay on the bus from SETUP through HOLD.
  assign addr_phase   = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign ide_cs       = addr_phase ? addr_q[4:3] : 2'b11;
  assign ide_da       = addr_phase ? addr_q[2:0] : 3'b111;
  assign ide_dior     = ~((state == S_STROBE) && is_rd);
  assign ide_diow     = ~((state == S_STROBE) && !is_rd);
  assign ide_data_bus = (addr_phase && !is_rd) ? wdata_q : {DATA_W{1'bz}};
  assign ata_busy     = (state != S_IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_ide_pio.sv
// tb_ide_pio: directed, self-checking bench for ide_pio (default timing
// T_SETUP=1, T_ACTIVE=3, T_RECOVER=2; IORDY_TIMEOUT=8 for the IORDY cases,
// which are compiled in only when IDE_IORDY_EN is defined).
module tb_ide_pio;
  import ide_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ata_rd = 1'b0;
  logic        ata_wr = 1'b0;
  logic [4:0]  ata_addr = 5'b0;
  logic [15:0] ata_in = 16'h0;
  logic [15:0] ata_out;
  logic        ata_done;
  logic        ata_busy;
  logic        ata_err;
  wire  [15:0] ide_data_bus;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic        ide_iordy = 1'b1;
  logic [2:0]  dbg_state;

  logic [15:0] dev_data = 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  // Simple drive model: answers reads while DIOR- is low.
  assign ide_data_bus = (!ide_dior) ? dev_data : 16'hzzzz;

  ide_pio #(
    .DATA_W        (16),
    .T_SETUP       (1),
    .T_ACTIVE      (3),
    .T_RECOVER     (2),
    .IORDY_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ata_rd       (ata_rd),
    .ata_wr       (ata_wr),
    .ata_addr     (ata_addr),
    .ata_in       (ata_in),
    .ata_out      (ata_out),
    .ata_done     (ata_done),
    .ata_busy     (ata_busy),
    .ata_err      (ata_err),
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da),
    .ide_iordy    (ide_iordy),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse during cycle N; returns in cycle N+1.
  task automatic issue(input logic rd, input logic wr, input logic [4:0] addr,
                       input logic [15:0] data);
    ata_rd   = rd;
    ata_wr   = wr;
    ata_addr = addr;
    ata_in   = data;
    cyc();
    ata_rd = 1'b0;
    ata_wr = 1'b0;
    ata_in = 16'h0;
  endtask

  // Checks cycles N+1..N+8 of a default-timing transaction.
  task automatic watch_txn(input string name, input logic rd, input logic [4:0] addr,
                           input logic [15:0] wdata);
    logic active;
    logic strb;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      active = (k <= 5);
      strb   = (k >= 2) && (k <= 4);
      check($sformatf("%s_cs_k%0d", name, k), ide_cs, active ? addr[4:3] : 2'b11);
      check($sformatf("%s_da_k%0d", name, k), ide_da, active ? addr[2:0] : 3'b111);
      check($sformatf("%s_dior_k%0d", name, k), ide_dior, (strb && rd) ? 1'b0 : 1'b1);
      check($sformatf("%s_diow_k%0d", name, k), ide_diow, (strb && !rd) ? 1'b0 : 1'b1);
      check($sformatf("%s_done_k%0d", name, k), ata_done, (k == 6));
      check($sformatf("%s_busy_k%0d", name, k), ata_busy, (k <= 7));
      if (!rd && active) begin
        check($sformatf("%s_bus_k%0d", name, k), ide_data_bus, wdata);
      end
      cyc();
    end
  endtask

  // Waits (bounded) for the engine to go idle, counting done pulses.
  task automatic wait_idle(input string name, output int dones);
    int i;
    dones = 0;
    i = 0;
    while (i < 30) begin
      @(negedge clk);
      if (ata_done) dones++;
      if (!ata_busy) break;
      cyc();
      i++;
    end
    check($sformatf("%s_idle", name), ata_busy, 1'b0);
    cyc();
  endtask

`ifdef IDE_IORDY_EN
  // Runs ncyc cycles after accept, releasing IORDY at the start of cycle
  // N+release_k+1 (release_k = 0 keeps it low).
  task automatic measure(input int ncyc, input int release_k, output int strobe_n,
                         output int done_k, output logic err_at_done);
    strobe_n    = 0;
    done_k      = -1;
    err_at_done = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!ide_dior) strobe_n++;
      if (ata_done) begin
        done_k      = k;
        err_at_done = ata_err;
      end
      cyc();
      if (k == release_k) ide_iordy = 1'b1;
    end
  endtask
`endif

  initial begin
    int dones;
`ifdef IDE_IORDY_EN
    int strobe_n;
    int done_k;
    logic err_d;
`endif

    // reset values
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", ata_out, 16'h0);
    check("rst_done", ata_done, 1'b0);
    check("rst_busy", ata_busy, 1'b0);
    check("rst_err", ata_err, 1'b0);
    check("rst_dior", ide_dior, 1'b1);
    check("rst_diow", ide_diow, 1'b1);
    check("rst_cs", ide_cs, 2'b11);
    check("rst_da", ide_da, 3'b111);
    check("rst_state", dbg_state, S_IDLE);
    cyc();
    repeat (3) cyc();

    // single read of STATUS
    dev_data = 16'h0050;
    issue(1'b1, 1'b0, ATA_REG_STATUS_CMD, 16'h0);
    watch_txn("rd1", 1'b1, ATA_REG_STATUS_CMD, 16'h0);
    check("rd1_out", ata_out, 16'h0050);

    // write to DATA: ata_out must keep the previous read
    issue(1'b0, 1'b1, ATA_REG_DATA, 16'hA55A);
    watch_txn("wr", 1'b0, ATA_REG_DATA, 16'hA55A);
    check("wr_out_kept", ata_out, 16'h0050);

    // read from the control block
    dev_data = 16'hBEEF;
    issue(1'b1, 1'b0, ATA_REG_ALTSTATUS, 16'h0);
    watch_txn("rd2", 1'b1, ATA_REG_ALTSTATUS, 16'h0);
    check("rd2_out", ata_out, 16'hBEEF);

    // collision: rd and wr together for 3 cycles -> nothing happens
    ata_rd   = 1'b1;
    ata_wr   = 1'b1;
    ata_addr = ATA_REG_DATA;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("col_busy_k%0d", k), ata_busy, 1'b0);
      check($sformatf("col_dior_k%0d", k), ide_dior, 1'b1);
      check($sformatf("col_diow_k%0d", k), ide_diow, 1'b1);
      check($sformatf("col_done_k%0d", k), ata_done, 1'b0);
      cyc();
      if (k == 2) begin
        ata_rd = 1'b0;
        ata_wr = 1'b0;
      end
    end
    check("col_out", ata_out, 16'hBEEF);

    // back-to-back: rd held high; second accept only at N+8
    dev_data = 16'h1234;
    ata_rd   = 1'b1;
    ata_addr = ATA_REG_DATA;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_k%0d", k), ata_busy, (k != 8));
      check($sformatf("b2b_done_k%0d", k), ata_done, (k == 6));
      check($sformatf("b2b_cs_k%0d", k), ide_cs, (k <= 5 || k == 9) ? 2'b10 : 2'b11);
      cyc();
    end
    ata_rd = 1'b0;
    wait_idle("b2b", dones);
    check("b2b_second_done", dones, 1);
    check("b2b_out", ata_out, 16'h1234);

`ifdef IDE_IORDY_EN
    // IORDY low across the end of T_ACTIVE, released at the start of N+5:
    // synchronised high in N+7, so strobe N+2..N+7, HOLD N+8, done N+9.
    repeat (2) cyc();
    dev_data  = 16'h0B0B;
    ide_iordy = 1'b0;
    issue(1'b1, 1'b0, ATA_REG_DATA, 16'h0);
    measure(20, 4, strobe_n, done_k, err_d);
    check("iordy_strobe_len", strobe_n, 6);
    check("iordy_done_k", done_k, 9);
    check("iordy_err", err_d, 1'b0);
    check("iordy_out", ata_out, 16'h0B0B);

    // IORDY stuck low: 3 + 8 strobe cycles, done at N+14 with error
    ide_iordy = 1'b0;
    issue(1'b1, 1'b0, ATA_REG_DATA, 16'h0);
    measure(20, 0, strobe_n, done_k, err_d);
    check("tmo_strobe_len", strobe_n, 11);
    check("tmo_done_k", done_k, 14);
    check("tmo_err", err_d, 1'b1);
    check("tmo_err_held", ata_err, 1'b1);
    ide_iordy = 1'b1;
    repeat (3) cyc();
`endif

    // reset during STROBE
    dev_data = 16'h7777;
    issue(1'b1, 1'b0, ATA_REG_STATUS_CMD, 16'h0);
    cyc();
    @(negedge clk);
    check("mid_in_strobe", ide_dior, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("mid_dior", ide_dior, 1'b1);
    check("mid_cs", ide_cs, 2'b11);
    check("mid_da", ide_da, 3'b111);
    check("mid_busy", ata_busy, 1'b0);
    check("mid_out", ata_out, 16'h0);
    check("mid_err", ata_err, 1'b0);
    cyc();
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ata_done) dones++;
      cyc();
    end
    check("mid_no_done", dones, 0);
    check("mid_out_after", ata_out, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
